fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 fifo_ctrl SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all registers.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 wr_en  input  1  write request, sampled on the clk rising edge.
REQ-005 rd_en  input  1  read request, sampled on the clk rising edge.
REQ-006 state  output  3  registered FIFO state, consumed by the downstream flag decoder.
REQ-007 data_count  output  4  registered occupancy, range 0..8.
REQ-008 head  output  3  registered read pointer into the 8-entry storage.
REQ-009 tail  output  3  registered write pointer into the 8-entry storage.
REQ-010 we  output  1  combinational storage write strobe; storage writes at tail on the same edge.
REQ-011 re  output  1  combinational storage read strobe; storage reads at head on the same edge.

Function
REQ-012 State encodings SHALL be INIT=000, NO_OP=001, WRITE=010, WR_ERR=011, READ=100, RD_ERR=101; codes 110 and 111 SHALL never be produced.
REQ-013 Next state SHALL be a function of wr_en, rd_en and the current data_count only; it SHALL NOT depend on the current state, and INIT is treated like any other state.
REQ-014 Transition table:
- wr_en=1, rd_en=0, count<8 -> WRITE.
- wr_en=1, rd_en=0, count=8 -> WR_ERR.
- rd_en=1, wr_en=0, count>0 -> READ.
- rd_en=1, wr_en=0, count=0 -> RD_ERR.
- Both 0 -> NO_OP.
- Both 1 -> NO_OP.
REQ-015 In the state WRITE, the block SHALL increment count and increment tail modulo 8 on the same edge; head is unchanged.
REQ-016 In the state READ, the block SHALL decrement count and increment head modulo 8 on the same edge; tail is unchanged.
REQ-017 In NO_OP, WR_ERR and RD_ERR, count, head and tail SHALL hold their values.
REQ-018 we SHALL equal wr_en & ~rd_en & (data_count!=8), and re SHALL equal rd_en & ~wr_en & (data_count!=0).
REQ-019 Latency: state and data_count SHALL reflect a request one edge after it is sampled, so the registered count is post-operation (WRITE implies 1..8, READ implies 0..7).
REQ-020 Simultaneous wr_en and rd_en SHALL be a no-operation, with no pointer movement and no error state, in any occupancy.
REQ-021 Wrap-around: the pointers SHALL roll 7->0 silently, and head==tail SHALL be disambiguated only by data_count (0 or 8).
REQ-022 Invariant: data_count SHALL always equal (tail-head) mod 8, except data_count=8 when tail==head while full.
REQ-023 data_count SHALL never exceed 8 and SHALL never underflow below 0.

Reset
REQ-024 While rst=1, the block SHALL force state=INIT, data_count=0, head=0 and tail=0 immediately, independent of clk.
REQ-025 A reset mid-operation SHALL discard any request sampled in that cycle, and storage contents SHALL be left undefined.
REQ-026 The first edge after rst deasserts SHALL follow REQ-014 with data_count=0.

Structure
REQ-027 A shared package fifo_pkg SHALL hold the six state encoding constants, DEPTH=8, the pointer width 3 and the count width 4, and SHALL be shared with the flag decoder.
REQ-028 Next-state logic SHALL be one combinational sub-module, fifo_ns (inputs: wr_en, rd_en, data_count; output: next_state).
REQ-029 Count, pointer and strobe logic SHALL stay in fifo_ctrl.

Verification
REQ-030 Reset then 8 writes -> state WRITE each cycle, data_count 1..8, tail 1,2,...,7,0, we=1 on each of the 8 edges.
REQ-031 With the FIFO full, a 9th write -> state=WR_ERR, data_count=8, we=0, tail=0 unchanged.
REQ-032 8 reads from full -> state READ, data_count 7..0, head wraps to 0; a further read -> RD_ERR, count 0, re=0.
REQ-033 wr_en=rd_en=1 at counts 0, 4 and 8 -> NO_OP, count and pointers unchanged, we=re=0.
REQ-034 Write 5, read 3, write 6 -> head=3, tail=3, data_count=8, the last write in WRITE state with count 8.
REQ-035 Assert rst asynchronously between edges at count=5 -> outputs go to INIT/0/0/0 before the next edge; a write after release -> count=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared encodings and sizes for the FIFO controller and its flag decoder.
package fifo_pkg;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned PTR_W   = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        INIT   = 3'b000,
        NO_OP  = 3'b001,
        WRITE  = 3'b010,
        WR_ERR = 3'b011,
        READ   = 3'b100,
        RD_ERR = 3'b101
    } state_t;

endpackage

// File: rtl/fifo_ns.sv
// Next-state decode for the FIFO controller: depends only on requests and occupancy.
module fifo_ns
    import fifo_pkg::*;
(
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [CNT_W-1:0] data_count,
    output state_t           next_state
);

    // Request/occupancy decode; simultaneous or absent requests are a no-op
    always_comb begin
        next_state = NO_OP;
        if (wr_en && !rd_en) begin
            next_state = (data_count == CNT_W'(DEPTH)) ? WR_ERR : WRITE;
        end else if (rd_en && !wr_en) begin
            next_state = (data_count == CNT_W'(0)) ? RD_ERR : READ;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Control for an 8-entry FIFO: state, occupancy, pointers and storage strobes.
module fifo_ctrl
    import fifo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   data_count,
    output logic [PTR_W-1:0]   head,
    output logic [PTR_W-1:0]   tail,
    output logic               we,
    output logic               re
);

    state_t next_state;

    fifo_ns u_ns (
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .data_count (data_count),
        .next_state (next_state)
    );

    // Storage strobes; these coincide exactly with the WRITE / READ decodes
    always_comb begin
        we = wr_en && !rd_en && (data_count != CNT_W'(DEPTH));
        re = rd_en && !wr_en && (data_count != CNT_W'(0));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STATE_W'(INIT);
        end else begin
            state <= STATE_W'(next_state);
        end
    end

    // Occupancy and pointers; pointers wrap naturally at 3 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_count <= '0;
            head       <= '0;
            tail       <= '0;
        end else begin
            if (we) begin
                data_count <= data_count + CNT_W'(1);
                tail       <= tail + PTR_W'(1);
            end else if (re) begin
                data_count <= data_count - CNT_W'(1);
                head       <= head + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl.
module tb_fifo_ctrl;

    localparam logic [2:0] S_INIT   = 3'b000;
    localparam logic [2:0] S_NO_OP  = 3'b001;
    localparam logic [2:0] S_WRITE  = 3'b010;
    localparam logic [2:0] S_WR_ERR = 3'b011;
    localparam logic [2:0] S_READ   = 3'b100;
    localparam logic [2:0] S_RD_ERR = 3'b101;

    typedef struct {
        logic [2:0] st;
        logic [3:0] cnt;
        logic [2:0] hd;
        logic [2:0] tl;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] state;
    logic [3:0] data_count;
    logic [2:0] head;
    logic [2:0] tail;
    logic       we;
    logic       re;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;
    int   m_cnt;
    int   m_head;
    int   m_tail;

    fifo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .state      (state),
        .data_count (data_count),
        .head       (head),
        .tail       (tail),
        .we         (we),
        .re         (re)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_state"}, 8'(state), 8'(S_INIT));
        check_eq({tag, "_count"}, 8'(data_count), 8'd0);
        check_eq({tag, "_head"}, 8'(head), 8'd0);
        check_eq({tag, "_tail"}, 8'(tail), 8'd0);
    endtask

    // One request cycle: check strobes before the edge, scoreboard result after it
    task automatic step(input logic w, input logic r);
        exp_t e;
        exp_t got;
        logic ew;
        logic er;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        #1;
        ew = w && !r && (m_cnt != 8);
        er = r && !w && (m_cnt != 0);
        check_eq("we", 8'(we), 8'(ew));
        check_eq("re", 8'(re), 8'(er));
        if (w && !r) begin
            e.st = (m_cnt < 8) ? S_WRITE : S_WR_ERR;
        end else if (r && !w) begin
            e.st = (m_cnt > 0) ? S_READ : S_RD_ERR;
        end else begin
            e.st = S_NO_OP;
        end
        if (ew) begin
            m_cnt++;
            m_tail = (m_tail + 1) % 8;
        end else if (er) begin
            m_cnt--;
            m_head = (m_head + 1) % 8;
        end
        e.cnt = 4'(m_cnt);
        e.hd  = 3'(m_head);
        e.tl  = 3'(m_tail);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 8'd1, 8'd0);
        end else begin
            got = sb.pop_front();
            check_eq("state", 8'(state), 8'(got.st));
            check_eq("count", 8'(data_count), 8'(got.cnt));
            check_eq("head", 8'(head), 8'(got.hd));
            check_eq("tail", 8'(tail), 8'(got.tl));
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        n_cmp  = 0;
        n_err  = 0;
        m_cnt  = 0;
        m_head = 0;
        m_tail = 0;

        #12;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, then overflow attempt
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        check_eq("full_tail_wrapped", 8'(tail), 8'd0);
        check_eq("full_count", 8'(data_count), 8'd8);
        step(1'b1, 1'b0);
        check_eq("wr_err_state", 8'(state), 8'(S_WR_ERR));

        // Simultaneous requests at full
        step(1'b1, 1'b1);

        // Drain, then underflow attempt
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        check_eq("empty_head_wrapped", 8'(head), 8'd0);
        step(1'b0, 1'b1);
        check_eq("rd_err_state", 8'(state), 8'(S_RD_ERR));
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Mixed traffic: ends full with head==tail==3
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        check_eq("mix_head", 8'(head), 8'd3);
        check_eq("mix_tail", 8'(tail), 8'd3);
        check_eq("mix_count", 8'(data_count), 8'd8);
        check_eq("mix_state", 8'(state), 8'(S_WRITE));

        // Random traffic
        for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Bring occupancy to 5, then reset between edges
        while (m_cnt > 5) step(1'b0, 1'b1);
        while (m_cnt < 5) step(1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        wr_en = 1'b1;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        check_idle("rst_held");
        m_cnt  = 0;
        m_head = 0;
        m_tail = 0;
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        step(1'b1, 1'b0);
        check_eq("post_rst_count", 8'(data_count), 8'd1);

        check_eq("sb_drained", 8'(sb.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
